// File: rtl/csr_access_ctrl_if.sv
// Bundles the execute-side request, CSR-unit and writeback-response signals
// of the Zicsr access controller.
interface csr_access_ctrl_if;
  // Handshakes: a request transfers on a clock edge where req_valid & req_ready
  // are both high; a response transfers where rsp_valid & rsp_ready are both high.
  // A valid side holds its payload stable until the transfer edge.
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_func3;
  logic [11:0] req_csr_addr;
  logic [4:0]  req_rs1_idx;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rd;
  logic        flush;

  logic [11:0] csr_addr;
  logic [2:0]  csr_func3;
  logic [4:0]  csr_imm;
  logic [31:0] csr_wdata;
  logic        csr_write_enable;
  logic [31:0] csr_rdata;
  logic        csr_write_done;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        rsp_illegal;
  logic        rsp_timeout;

  modport master (
    output req_valid, req_func3, req_csr_addr, req_rs1_idx, req_rs1_data, req_rd,
           flush, csr_rdata, csr_write_done, rsp_ready,
    input  req_ready, csr_addr, csr_func3, csr_imm, csr_wdata, csr_write_enable,
           rsp_valid, rsp_rd, rsp_data, rsp_illegal, rsp_timeout
  );

  modport slave (
    input  req_valid, req_func3, req_csr_addr, req_rs1_idx, req_rs1_data, req_rd,
           flush, csr_rdata, csr_write_done, rsp_ready,
    output req_ready, csr_addr, csr_func3, csr_imm, csr_wdata, csr_write_enable,
           rsp_valid, rsp_rd, rsp_data, rsp_illegal, rsp_timeout
  );
endinterface

// File: rtl/csr_access_ctrl.sv
// Zicsr sequencer: read old CSR value, compute RW/RS/RC result, issue one write
// strobe, wait for the CSR unit's acknowledge and return the old value.
module csr_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  csr_access_ctrl_if.slave   bus,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          flushed;
  logic [31:0]   rs1_data_q;
  logic [4:0]    rd_q;

  logic [31:0]   src;
  logic [31:0]   new_val;
  logic          do_write;
  logic          illegal;
  logic          wait_over;
  logic          flush_pending;

  // Operand decode works off the latched request, valid while in READ.
  always_comb begin
    src = bus.csr_func3[2] ? {27'b0, bus.csr_imm} : rs1_data_q;
    case (bus.csr_func3[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = bus.csr_rdata | src;
      2'b11:   new_val = bus.csr_rdata & ~src;
      default: new_val = bus.csr_rdata;
    endcase
    // imm holds the rs1 index for register forms, so x0/uimm=0 both suppress RS/RC writes
    do_write      = (bus.csr_func3[1:0] == 2'b01) | (bus.csr_imm != 5'd0);
    illegal       = (bus.csr_func3[1:0] == 2'b00) |
                    (do_write & (bus.csr_addr[11:10] == 2'b11));
    wait_over     = bus.csr_write_done | (wait_cnt == CNT_LAST);
    flush_pending = flushed | bus.flush;
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      wait_cnt             <= '0;
      flushed              <= 1'b0;
      rs1_data_q           <= '0;
      rd_q                 <= '0;
      bus.req_ready        <= 1'b1;
      bus.csr_addr         <= '0;
      bus.csr_func3        <= '0;
      bus.csr_imm          <= '0;
      bus.csr_wdata        <= '0;
      bus.csr_write_enable <= 1'b0;
      bus.rsp_valid        <= 1'b0;
      bus.rsp_rd           <= '0;
      bus.rsp_data         <= '0;
      bus.rsp_illegal      <= 1'b0;
      bus.rsp_timeout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.csr_addr  <= bus.req_csr_addr;
            bus.csr_func3 <= bus.req_func3;
            bus.csr_imm   <= bus.req_rs1_idx;
            rs1_data_q    <= bus.req_rs1_data;
            rd_q          <= bus.req_rd;
            flushed       <= 1'b0;
            bus.req_ready <= 1'b0;
            state         <= READ;
          end
        end
        READ: begin
          if (bus.flush) begin
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            bus.rsp_data <= bus.csr_rdata;
            bus.rsp_rd   <= illegal ? 5'd0 : rd_q;
            if (illegal || !do_write) begin
              bus.rsp_illegal <= illegal;
              bus.rsp_valid   <= 1'b1;
              state           <= RESP;
            end else begin
              bus.csr_wdata        <= new_val;
              bus.csr_write_enable <= 1'b1;
              state                <= WRITE;
            end
          end
        end
        WRITE: begin
          bus.csr_write_enable <= 1'b0;
          wait_cnt             <= '0;
          flushed              <= flush_pending;
          state                <= WAIT;
        end
        WAIT: begin
          // A flush here lets the write finish, then drops the response.
          if (wait_over) begin
            if (flush_pending) begin
              bus.req_ready <= 1'b1;
              state         <= IDLE;
            end else begin
              bus.rsp_timeout <= !bus.csr_write_done;
              bus.rsp_valid   <= 1'b1;
              state           <= RESP;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            flushed  <= flush_pending;
          end
        end
        RESP: begin
          if (bus.rsp_ready || bus.flush) begin
            bus.rsp_valid   <= 1'b0;
            bus.rsp_illegal <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.req_ready   <= 1'b1;
            state           <= IDLE;
          end
        end
        default: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
